// File: rtl/jtopl_wrseq.sv
// Write scheduler for jtopl_mmr: queues {reg,val} pairs and replays them as address/data
// strobes with cen-paced recovery gaps. Optional macro JTOPL_WRSEQ_ADDRSKIP_EN skips repeated index writes.
module jtopl_wrseq #(
  parameter int AW        = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84,
  parameter int CW        = 8
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_reg,
  input  logic [7:0]    req_val,
  output logic          mmr_write,
  output logic          mmr_addr,
  output logic [7:0]    mmr_din,
  output logic          busy,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] AWAIT = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] DWAIT = 3'd4;

  logic [15:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;

  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [7:0]    cur_reg;
  logic [7:0]    cur_val;

  logic          mmr_write_reg;
  logic          mmr_addr_reg;
  logic [7:0]    mmr_din_reg;
  logic          busy_reg;

  logic          push;
  logic          pop;
  logic          skip_hit;

  // A push coinciding with flush is dropped; flush also blocks the pop so nothing new starts.
  assign req_ready = (level_reg != FULL_LEVEL);
  assign push      = req_valid && req_ready && !flush;
  assign pop       = (state_reg == IDLE) && (level_reg != '0) && !flush;

  assign mmr_write = mmr_write_reg;
  assign mmr_addr  = mmr_addr_reg;
  assign mmr_din   = mmr_din_reg;
  assign busy      = busy_reg;
  assign level     = level_reg;

  // Storage and its registered read port carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {req_reg, req_val};
    end
    if (pop) begin
      {cur_reg, cur_val} <= fifo_mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= wr_ptr_reg;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

`ifdef JTOPL_WRSEQ_ADDRSKIP_EN
  logic [7:0] last_idx_reg;
  logic       last_valid_reg;

  // The skip is resolved in ADDR, where the popped pair is already registered; the data
  // strobe then lands on the same clk the address strobe would have.
  assign skip_hit = last_valid_reg && (cur_reg == last_idx_reg);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      last_valid_reg <= 1'b0;
      last_idx_reg   <= '0;
    end else if ((state_reg == ADDR) && !skip_hit) begin
      last_valid_reg <= 1'b1;
      last_idx_reg   <= cur_reg;
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mmr_write_reg <= 1'b0;
      mmr_addr_reg  <= 1'b0;
      mmr_din_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      mmr_write_reg <= 1'b0;
      busy_reg      <= (level_reg != '0) || (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          mmr_write_reg <= 1'b1;
          if (skip_hit) begin
            mmr_addr_reg <= 1'b1;
            mmr_din_reg  <= cur_val;
            cnt_reg      <= CW'(DATA_WAIT);
            state_reg    <= DWAIT;
          end else begin
            mmr_addr_reg <= 1'b0;
            mmr_din_reg  <= cur_reg;
            cnt_reg      <= CW'(ADDR_WAIT);
            state_reg    <= AWAIT;
          end
        end
        AWAIT: begin
          // The last counted tick moves on directly, so the gap is wait+1 clk at full cen rate.
          if (cnt_reg == '0) begin
            state_reg <= DATA;
          end else if (cen) begin
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          mmr_write_reg <= 1'b1;
          mmr_addr_reg  <= 1'b1;
          mmr_din_reg   <= cur_val;
          cnt_reg       <= CW'(DATA_WAIT);
          state_reg     <= DWAIT;
        end
        DWAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end else if (cen) begin
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// Scoreboard bench for jtopl_wrseq: expected strobes are queued on each accepted push
// and checked as the DUT emits them; honours JTOPL_WRSEQ_ADDRSKIP_EN.
module tb_jtopl_wrseq;

`ifdef JTOPL_WRSEQ_ADDRSKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       rst, clk, cen, flush, req_valid, req_ready;
  logic [7:0] req_reg, req_val;
  logic       mmr_write, mmr_addr;
  logic [7:0] mmr_din;
  logic       busy;
  logic [4:0] level;

  jtopl_wrseq #(.AW(4), .ADDR_WAIT(12), .DATA_WAIT(84), .CW(8)) dut (
    .rst(rst), .clk(clk), .cen(cen), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_val(req_val),
    .mmr_write(mmr_write), .mmr_addr(mmr_addr), .mmr_din(mmr_din),
    .busy(busy), .level(level)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] exp_q [$];
  bit         m_valid = 1'b0;
  logic [7:0] m_last  = '0;

  int cyc = 0, cen_cnt = 0, strobe_cnt = 0, addr_cnt = 0;
  int t_addr = 0, t_data = 0, cen_a = 0, last_ticks = 0, acc_cyc = 0;
  int cen_mode = 0;
  bit last_cen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cen = 1'b0;
    forever begin
      @(negedge clk);
      case (cen_mode)
        0:       cen = 1'b1;
        1:       cen = 1'b0;
        default: cen = (cyc % 4 == 0);
      endcase
    end
  end

  // Output monitor: sampled 1 time unit after each active edge.
  initial begin : monitor
    bit         r;
    bit         prev_write = 1'b0;
    logic [7:0] last_din = '0;
    logic [9:0] obs, exp;
    forever begin
      @(posedge clk);
      cyc++;
      if (cen) cen_cnt++;
      last_cen = cen;
      r = rst;
      #1;
      if (r) begin
        last_din   = '0;
        prev_write = 1'b0;
      end else if (mmr_write) begin
        obs = {1'b1, mmr_addr, mmr_din};
        exp = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : 10'h0;
        chk("strobe", obs, exp);
        chk("dbl_strobe", prev_write, 0);
        $display("cyc %0d strobe addr=%0d din=%02h", cyc, mmr_addr, mmr_din);
        strobe_cnt++;
        if (!mmr_addr) begin
          addr_cnt++;
          t_addr = cyc;
          cen_a  = cen_cnt;
        end else begin
          t_data     = cyc;
          last_ticks = cen_cnt - int'(last_cen) - cen_a;
        end
        last_din   = mmr_din;
        prev_write = 1'b1;
      end else begin
        chk("din_hold", mmr_din, last_din);
        prev_write = 1'b0;
      end
    end
  end

  function automatic void model_push(input logic [7:0] r, input logic [7:0] v);
    if (!(SKIP && m_valid && m_last == r)) exp_q.push_back({1'b0, r});
    exp_q.push_back({1'b1, v});
    m_valid = 1'b1;
    m_last  = r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_valid = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_write", mmr_write, 0);
    chk("rst_addr", mmr_addr, 0);
    chk("rst_din", mmr_din, 0);
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] v);
    int k = 0;
    @(negedge clk);
    req_valid = 1'b1; req_reg = r; req_val = v;
    while (!req_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk("push_timeout", req_ready, 1);
    model_push(r, v);
    acc_cyc = cyc + 1;
  endtask

  task automatic release_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_strobes(input string tag, input int target);
    int k = 0;
    while (strobe_cnt < target && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (strobe_cnt < target) chk(tag, strobe_cnt, target);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin : stim
    int s0, a0, off, tgt;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_reg = '0; req_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("init_level", level, 0);
    chk("init_ready", req_ready, 1);
    chk("init_busy", busy, 0);

    // 1: single pair, cen every clk
    cen_mode = 0;
    do_reset();
    s0 = strobe_cnt;
    push(8'h20, 8'h01);
    release_req();
    wait_strobes("t1_strobes", s0 + 2);
    chk("t1_latency", t_addr - acc_cyc, 2);
    chk("t1_gap", t_data - t_addr, 13);
    wait_idle("t1_idle");
    chk("t1_busy_drop", cyc - t_data, 85);

    // 2: FIFO fill with the FSM stalled in AWAIT
    cen_mode = 1;
    do_reset();
    s0 = strobe_cnt;
    push(8'h30, 8'hAA);
    release_req();
    wait_strobes("t2_stall_addr", s0 + 1);
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 8'(i));
    @(negedge clk);
    req_reg = 8'h50; req_val = 8'h55;
    chk("t2_level_full", level, 16);
    chk("t2_ready_full", req_ready, 0);
    repeat (5) @(negedge clk);
    chk("t2_level_held", level, 16);
    chk("t2_ready_held", req_ready, 0);
    cen_mode = 0;
    push(8'h50, 8'h55);
    release_req();
    tgt = strobe_cnt + exp_q.size();
    wait_strobes("t2_drain", tgt);
    wait_idle("t2_idle");

    // 3: cen one clk in four
    cen_mode = 2;
    do_reset();
    s0 = strobe_cnt;
    push(8'hB0, 8'h5A);
    release_req();
    wait_strobes("t3_strobes", s0 + 2);
    off = (5 - (t_addr % 4)) % 4;
    if (off == 0) off = 4;
    chk("t3_cen_ticks", last_ticks, 12);
    chk("t3_gap", t_data - t_addr, off + 45);
    wait_idle("t3_idle");

    // 4: flush during AWAIT with 5 queued, plus a push dropped by the flush
    cen_mode = 0;
    do_reset();
    s0 = strobe_cnt;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 8'h10 + 8'(i));
    @(negedge clk);
    chk("t4_level", level, 5);
    chk("t4_ready_flush", req_ready, 1);
    flush = 1'b1; req_reg = 8'h99; req_val = 8'h77;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    m_valid = 1'b0;
    chk("t4_level_flushed", level, 0);
    chk("t4_ready_flushed", req_ready, 1);
    wait_strobes("t4_data", s0 + 2);
    wait_idle("t4_idle");
    repeat (20) @(negedge clk);
    chk("t4_strobe_count", strobe_cnt, s0 + 2);

    // 5a: reset during DWAIT
    do_reset();
    s0 = strobe_cnt;
    push(8'h70, 8'h01);
    release_req();
    wait_strobes("t5a_strobes", s0 + 2);
    repeat (10) @(negedge clk);
    do_reset();

    // 5b: reset during AWAIT; data strobe must never appear
    s0 = strobe_cnt;
    push(8'h71, 8'h02);
    release_req();
    wait_strobes("t5b_addr", s0 + 1);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (120) @(negedge clk);
    chk("t5b_no_data", strobe_cnt, s0 + 1);

    // 6: repeated register index
    do_reset();
    s0 = strobe_cnt;
    a0 = addr_cnt;
    push(8'hA0, 8'h11);
    push(8'hA0, 8'h22);
    release_req();
    wait_strobes("t6_strobes", s0 + (SKIP ? 3 : 4));
    wait_idle("t6_idle");
    chk("t6_addr_strobes", addr_cnt - a0, SKIP ? 1 : 2);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
